// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS ID/EX control path:
//   - opcode constants for every instruction the decoder understands
//   - ALU operation codes (R-type funct encoding reused for immediates)
//   - one-hot memory access size encodings
//   - the control word carried from ID into EX, plus small helpers
//   - halt sequencer state constants
// ---------------------------------------------------------------------------
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ADDIU = 6'b010001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU operation codes
    localparam logic [5:0] ALU_NOP = 6'b000000;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SLT = 6'b101010;

    // Memory access size, one-hot
    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_BYTE = 3'b001;
    localparam logic [2:0] MEM_HALF = 3'b010;
    localparam logic [2:0] MEM_WORD = 3'b100;

    // Halt sequencer states
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Control word handed from ID to EX. Widths here are the native
    // encodings; the pipeline register resizes them to its parameters.
    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_sign;
        logic       alu_src;
        logic       reg_write;
        logic       branch;
        logic       branch_eq;
        logic       jump;
        logic       sign_ext;
        logic [5:0] alu_ctrl;
        logic [2:0] mem_op;
        logic [4:0] wreg;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    // Register-immediate ALU instruction writing dst.
    function automatic ctrl_word_t imm_op(input logic [5:0] alu,
                                          input logic       sext,
                                          input logic [4:0] dst);
        ctrl_word_t c;
        c           = CTRL_BUBBLE;
        c.valid     = 1'b1;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.sign_ext  = sext;
        c.alu_ctrl  = alu;
        c.wreg      = dst;
        return c;
    endfunction

    // Loads and stores share op[1:0] as the access size: 00 byte,
    // 01 half, 11 word.
    function automatic logic [2:0] mem_size(input logic [5:0] opcode);
        logic [2:0] sz;
        case (opcode[1:0])
            2'b00:   sz = MEM_BYTE;
            2'b01:   sz = MEM_HALF;
            default: sz = MEM_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational instruction decoder: op/funct/register fields to
// the EX control word, plus the operand-usage flags needed for hazard
// detection and the HALT / illegal classification.
//   i_op, i_funct     : opcode and R-type function
//   i_rt, i_rd        : register fields used to pick the destination
//   o_ctrl            : control word (bubble for HALT and illegal ops)
//   o_uses_rs/o_uses_rt : instruction reads rs / rt
//   o_is_halt         : opcode is HALT
//   o_is_illegal      : opcode is not decodable
// ---------------------------------------------------------------------------
module control_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    input  logic [4:0] i_rd,
    output ctrl_word_t o_ctrl,
    output logic       o_uses_rs,
    output logic       o_uses_rt,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    always_comb begin
        o_ctrl       = CTRL_BUBBLE;
        o_uses_rs    = 1'b1;
        o_uses_rt    = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;

        case (i_op)
            OP_RTYPE: begin
                o_ctrl.valid     = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_ctrl  = i_funct;
                o_ctrl.wreg      = i_rd;
                o_uses_rt        = 1'b1;
            end
            OP_ADDI, OP_ADDIU:  o_ctrl = imm_op(ALU_ADD, 1'b1, i_rt);
            OP_ANDI:            o_ctrl = imm_op(ALU_AND, 1'b0, i_rt);
            OP_ORI:             o_ctrl = imm_op(ALU_OR,  1'b0, i_rt);
            OP_XORI:            o_ctrl = imm_op(ALU_XOR, 1'b0, i_rt);
            OP_SLTI, OP_SLTIU:  o_ctrl = imm_op(ALU_SLT, 1'b1, i_rt);
            OP_BEQ, OP_BNE: begin
                // Compare by subtraction; offset is sign-extended.
                o_ctrl.valid     = 1'b1;
                o_ctrl.branch    = 1'b1;
                o_ctrl.branch_eq = ~i_op[0];
                o_ctrl.sign_ext  = 1'b1;
                o_ctrl.alu_ctrl  = ALU_SUB;
                o_uses_rt        = 1'b1;
            end
            OP_J: begin
                o_ctrl.valid = 1'b1;
                o_ctrl.jump  = 1'b1;
                o_uses_rs    = 1'b0;
            end
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU: begin
                // Address = rs + sign-extended offset; op[2] marks the
                // unsigned variants.
                o_ctrl            = imm_op(ALU_ADD, 1'b1, i_rt);
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.mem_op     = mem_size(i_op);
                o_ctrl.mem_sign   = ~i_op[2];
            end
            OP_SB, OP_SH, OP_SW: begin
                o_ctrl           = imm_op(ALU_ADD, 1'b1, 5'd0);
                o_ctrl.reg_write = 1'b0;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.mem_op    = mem_size(i_op);
                o_uses_rt        = 1'b1;
            end
            OP_HALT: begin
                // HALT is a sequencing request only; nothing enters EX.
                o_is_halt = 1'b1;
                o_uses_rs = 1'b0;
            end
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit_pipe.sv
// ---------------------------------------------------------------------------
// control_unit_pipe
// ID/EX control register for the MIPS pipeline: decodes the instruction in
// ID, registers its control word for EX, inserts bubbles for flush, load-use
// hazards and while halting, flags illegal opcodes and sequences HALT.
//   clk, reset_n        : clock, asynchronous active-low reset
//   valid_in, op, funct : instruction in ID
//   rs, rt, rd          : register fields of the instruction in ID
//   stall               : hold everything (from later stages)
//   flush               : squash the instruction in ID
//   hazard_stall        : combinational load-use stall of PC and IF/ID
//   ex_*                : registered EX control word
//   illegal             : one-cycle pulse for an undecodable valid opcode
//   halt_pending/halted : sticky halt status
// ---------------------------------------------------------------------------
module control_unit_pipe
    import mips_pkg::*;
#(
    parameter int unsigned ALUCTRL_W    = 6,
    parameter int unsigned MEMOP_W      = 3,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned LOAD_USE_EN  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_in,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic [4:0]           rs,
    input  logic [4:0]           rt,
    input  logic [4:0]           rd,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 hazard_stall,
    output logic                 ex_valid,
    output logic                 ex_mem_to_reg,
    output logic                 ex_mem_write,
    output logic                 ex_mem_sign,
    output logic                 ex_alu_src,
    output logic                 ex_reg_write,
    output logic                 ex_branch,
    output logic                 ex_branch_eq,
    output logic                 ex_jump,
    output logic                 ex_sign_ext,
    output logic [ALUCTRL_W-1:0] ex_alu_ctrl,
    output logic [MEMOP_W-1:0]   ex_mem_op,
    output logic [4:0]           ex_wreg,
    output logic                 illegal,
    output logic                 halt_pending,
    output logic                 halted
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    ctrl_word_t r_ex;
    logic       r_illegal;
    logic [1:0] r_state;
    logic [3:0] r_drain_cnt;

    ctrl_word_t w_dec_ctrl;
    ctrl_word_t w_ex_next;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_hazard;
    logic       w_running;
    logic       w_halt_accept;
    logic       w_illegal_next;
    logic [1:0] w_state_next;
    logic [3:0] w_cnt_next;

    control_decode u_decode (
        .i_op         (op),
        .i_funct      (funct),
        .i_rt         (rt),
        .i_rd         (rd),
        .o_ctrl       (w_dec_ctrl),
        .o_uses_rs    (w_uses_rs),
        .o_uses_rt    (w_uses_rt),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    assign w_running = (r_state == ST_RUN);

    // Load in EX whose result is needed by the instruction in ID. The
    // bubble inserted below moves the load on, so the hit lasts one cycle.
    generate
        if (LOAD_USE_EN != 0) begin : g_load_use
            assign w_hazard = valid_in && w_running &&
                              r_ex.valid && r_ex.mem_to_reg && (r_ex.wreg != 5'd0) &&
                              (((r_ex.wreg == rs) && w_uses_rs) ||
                               ((r_ex.wreg == rt) && w_uses_rt));
        end else begin : g_no_load_use
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign hazard_stall = w_hazard;

    // EX register next value, in priority order.
    always_comb begin
        w_ex_next      = r_ex;
        w_illegal_next = 1'b0;
        if (stall) begin
            w_ex_next = r_ex;
        end else if (flush || !w_running || w_hazard || !valid_in) begin
            w_ex_next = CTRL_BUBBLE;
        end else begin
            // Decoder already yields a bubble for HALT and illegal ops.
            w_ex_next      = w_dec_ctrl;
            w_illegal_next = w_is_illegal;
        end
    end

    assign w_halt_accept = valid_in && w_is_halt && !stall && !flush && !w_hazard && w_running;

    // Halt sequencer: the drain counter only moves on cycles where the
    // pipeline itself advances.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_halt_accept) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (r_drain_cnt <= 4'd1) begin
                        w_state_next = ST_HALTED;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next = r_drain_cnt - 4'd1;
                    end
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex        <= CTRL_BUBBLE;
            r_illegal   <= 1'b0;
            r_state     <= ST_RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_ex        <= w_ex_next;
            r_illegal   <= w_illegal_next;
            r_state     <= w_state_next;
            r_drain_cnt <= w_cnt_next;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_mem_to_reg = r_ex.mem_to_reg;
    assign ex_mem_write  = r_ex.mem_write;
    assign ex_mem_sign   = r_ex.mem_sign;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_branch     = r_ex.branch;
    assign ex_branch_eq  = r_ex.branch_eq;
    assign ex_jump       = r_ex.jump;
    assign ex_sign_ext   = r_ex.sign_ext;
    assign ex_alu_ctrl   = ALUCTRL_W'(r_ex.alu_ctrl);
    assign ex_mem_op     = MEMOP_W'(r_ex.mem_op);
    assign ex_wreg       = r_ex.wreg;
    assign illegal       = r_illegal;
    assign halt_pending  = (r_state != ST_RUN);
    assign halted        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_control_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_control_unit_pipe
// Directed and randomized stimulus against an instruction-table reference
// model of the ID/EX control register.
// ---------------------------------------------------------------------------
module tb_control_unit_pipe;

    localparam int DRAIN = 4;

    localparam bit [5:0] T_R    = 6'b000000;
    localparam bit [5:0] T_J    = 6'b000010;
    localparam bit [5:0] T_ADDI = 6'b001000;
    localparam bit [5:0] T_ORI  = 6'b001101;
    localparam bit [5:0] T_XORI = 6'b001110;
    localparam bit [5:0] T_LW   = 6'b100011;
    localparam bit [5:0] T_HALT = 6'b111111;
    localparam bit [5:0] T_BAD  = 6'b110011;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_in;
    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       stall, flush;
    logic       hazard_stall;
    logic       ex_valid, ex_mem_to_reg, ex_mem_write, ex_mem_sign, ex_alu_src;
    logic       ex_reg_write, ex_branch, ex_branch_eq, ex_jump, ex_sign_ext;
    logic [5:0] ex_alu_ctrl;
    logic [2:0] ex_mem_op;
    logic [4:0] ex_wreg;
    logic       illegal, halt_pending, halted;

    always #5 clk = ~clk;

    control_unit_pipe #(
        .ALUCTRL_W(6), .MEMOP_W(3), .DRAIN_CYCLES(DRAIN), .LOAD_USE_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .op(op), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_mem_sign(ex_mem_sign), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_branch_eq(ex_branch_eq),
        .ex_jump(ex_jump), .ex_sign_ext(ex_sign_ext), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_mem_op(ex_mem_op), .ex_wreg(ex_wreg), .illegal(illegal),
        .halt_pending(halt_pending), .halted(halted)
    );

    int n_vec = 0;
    int n_err = 0;

    // Instruction table: word = {valid,m2r,mw,msign,src,rw,br,beq,j,sext, alu[6], mop[3], wreg[5]}
    bit [23:0] tbl_word [64];
    bit        tbl_known[64];
    bit        tbl_rt   [64];

    // Reference state
    bit [23:0] m_ex;
    bit        m_ill, m_pend, m_halted;
    int        m_left;

    bit [5:0]  rops[$];

    task automatic add(input bit [5:0] o, input bit [9:0] fl, input bit [5:0] alu,
                       input bit [2:0] mop, input bit reads_rt);
        tbl_known[o] = 1'b1;
        tbl_word[o]  = {fl, alu, mop, 5'd0};
        tbl_rt[o]    = reads_rt;
    endtask

    function automatic bit [23:0] lookup(input bit [5:0] o, input bit [5:0] f,
                                         input bit [4:0] t, input bit [4:0] d);
        bit [23:0] w;
        w = tbl_word[o];
        if (o == T_R) w[13:8] = f;
        if (w[18]) w[4:0] = (o == T_R) ? d : t;
        return w;
    endfunction

    function automatic bit [23:0] dut_word();
        return {ex_valid, ex_mem_to_reg, ex_mem_write, ex_mem_sign, ex_alu_src,
                ex_reg_write, ex_branch, ex_branch_eq, ex_jump, ex_sign_ext,
                ex_alu_ctrl, ex_mem_op, ex_wreg};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive, check the combinational stall, advance the model,
    // clock, then check the registered outputs.
    task automatic step(input bit v, input bit [5:0] o, input bit [5:0] f,
                        input bit [4:0] s, input bit [4:0] t, input bit [4:0] d,
                        input bit st, input bit fl);
        bit hz, known, is_halt, urs, urt, accept;
        valid_in = v; op = o; funct = f; rs = s; rt = t; rd = d; stall = st; flush = fl;
        known   = tbl_known[o];
        is_halt = (o == T_HALT);
        urs     = !(o == T_J || is_halt);
        urt     = tbl_rt[o];
        hz = v && !m_pend && m_ex[23] && m_ex[22] && (m_ex[4:0] != 5'd0) &&
             (((m_ex[4:0] == s) && urs) || ((m_ex[4:0] == t) && urt));
        #1;
        check("hazard_stall", 32'(hazard_stall), 32'(hz));
        accept = v && is_halt && !st && !fl && !hz && !m_pend;
        m_ill = 1'b0;
        if (!st) begin
            if (fl || m_pend || hz || !v || !known) m_ex = '0;
            else m_ex = lookup(o, f, t, d);
            m_ill = v && !known && !is_halt && !fl && !m_pend && !hz;
        end
        if (m_pend && !m_halted && !st) begin
            m_left--;
            if (m_left == 0) m_halted = 1'b1;
        end
        if (accept) begin
            m_pend = 1'b1;
            m_left = DRAIN;
        end
        @(posedge clk);
        #1;
        check("ex_word", 32'(dut_word()), 32'(m_ex));
        check("illegal", 32'(illegal), 32'(m_ill));
        check("halt_pending", 32'(halt_pending), 32'(m_pend));
        check("halted", 32'(halted), 32'(m_halted));
        $display("step v=%0b op=%b f=%b rs=%0d rt=%0d rd=%0d st=%0b fl=%0b -> hz=%0b ex=%h ill=%0b hp=%0b h=%0b",
                 v, o, f, s, t, d, st, fl, hazard_stall, dut_word(), illegal, halt_pending, halted);
    endtask

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic do_reset();
        valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
        reset_n = 1'b0;
        #2;
        m_ex = '0; m_ill = 1'b0; m_pend = 1'b0; m_halted = 1'b0; m_left = 0;
        check("rst_ex_word", 32'(dut_word()), 32'(m_ex));
        check("rst_illegal", 32'(illegal), 32'(0));
        check("rst_halt_pending", 32'(halt_pending), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_hazard", 32'(hazard_stall), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        $display("reset applied");
    endtask

    initial begin
        bit [5:0] ro;
        //          v m2r mw ms src rw br beq j sx
        add(6'b001000, 10'b1_0_0_0_1_1_0_0_0_1, 6'b100000, 3'b000, 1'b0); // ADDI
        add(6'b010001, 10'b1_0_0_0_1_1_0_0_0_1, 6'b100000, 3'b000, 1'b0); // ADDIU
        add(6'b001100, 10'b1_0_0_0_1_1_0_0_0_0, 6'b100100, 3'b000, 1'b0); // ANDI
        add(6'b001101, 10'b1_0_0_0_1_1_0_0_0_0, 6'b100101, 3'b000, 1'b0); // ORI
        add(6'b001110, 10'b1_0_0_0_1_1_0_0_0_0, 6'b100110, 3'b000, 1'b0); // XORI
        add(6'b001010, 10'b1_0_0_0_1_1_0_0_0_1, 6'b101010, 3'b000, 1'b0); // SLTI
        add(6'b001011, 10'b1_0_0_0_1_1_0_0_0_1, 6'b101010, 3'b000, 1'b0); // SLTIU
        add(6'b000100, 10'b1_0_0_0_0_0_1_1_0_1, 6'b100010, 3'b000, 1'b1); // BEQ
        add(6'b000101, 10'b1_0_0_0_0_0_1_0_0_1, 6'b100010, 3'b000, 1'b1); // BNE
        add(6'b000010, 10'b1_0_0_0_0_0_0_0_1_0, 6'b000000, 3'b000, 1'b0); // J
        add(6'b100000, 10'b1_1_0_1_1_1_0_0_0_1, 6'b100000, 3'b001, 1'b0); // LB
        add(6'b100100, 10'b1_1_0_0_1_1_0_0_0_1, 6'b100000, 3'b001, 1'b0); // LBU
        add(6'b100001, 10'b1_1_0_1_1_1_0_0_0_1, 6'b100000, 3'b010, 1'b0); // LH
        add(6'b100101, 10'b1_1_0_0_1_1_0_0_0_1, 6'b100000, 3'b010, 1'b0); // LHU
        add(6'b100011, 10'b1_1_0_1_1_1_0_0_0_1, 6'b100000, 3'b100, 1'b0); // LW
        add(6'b100111, 10'b1_1_0_0_1_1_0_0_0_1, 6'b100000, 3'b100, 1'b0); // LWU
        add(6'b101000, 10'b1_0_1_0_1_0_0_0_0_1, 6'b100000, 3'b001, 1'b1); // SB
        add(6'b101001, 10'b1_0_1_0_1_0_0_0_0_1, 6'b100000, 3'b010, 1'b1); // SH
        add(6'b101011, 10'b1_0_1_0_1_0_0_0_0_1, 6'b100000, 3'b100, 1'b1); // SW
        add(6'b000000, 10'b1_0_0_0_0_1_0_0_0_0, 6'b000000, 3'b000, 1'b1); // R-type

        for (int i = 0; i < 64; i++) if (tbl_known[i]) rops.push_back(6'(i));
        rops.push_back(T_LW); rops.push_back(T_LW); rops.push_back(6'b100000);
        rops.push_back(T_BAD); rops.push_back(6'b000001);

        valid_in = 1'b0; op = '0; funct = '0; rs = '0; rt = '0; rd = '0;
        stall = 1'b0; flush = 1'b0; reset_n = 1'b1;
        #1;
        do_reset();

        // ADDI decode
        step(1, T_ADDI, 6'd0, 5'd3, 5'd9, 5'd2, 0, 0);
        check("addi_alu", 32'(ex_alu_ctrl), 32'(6'b100000));
        check("addi_src", 32'(ex_alu_src), 32'(1));
        check("addi_sext", 32'(ex_sign_ext), 32'(1));
        check("addi_wreg", 32'(ex_wreg), 32'(9));

        // Load-use: one stall, bubble, then ADD proceeds
        step(1, T_LW, 6'd0, 5'd1, 5'd5, 5'd0, 0, 0);
        step(1, T_R, 6'b100000, 5'd5, 5'd1, 5'd7, 0, 0);
        check("lu_bubble_valid", 32'(ex_valid), 32'(0));
        step(1, T_R, 6'b100000, 5'd5, 5'd1, 5'd7, 0, 0);
        check("lu_add_wreg", 32'(ex_wreg), 32'(7));
        check("lu_add_rw", 32'(ex_reg_write), 32'(1));
        // Load into r0 never stalls
        step(1, T_LW, 6'd0, 5'd1, 5'd0, 5'd0, 0, 0);
        step(1, T_R, 6'b100000, 5'd0, 5'd1, 5'd7, 0, 0);
        check("lu_r0_valid", 32'(ex_valid), 32'(1));

        // Stall holds EX for three cycles
        step(1, T_ADDI, 6'd0, 5'd3, 5'd12, 5'd2, 0, 0);
        step(1, T_ORI, 6'd0, 5'd3, 5'd4, 5'd2, 1, 0);
        step(1, T_R, 6'b100010, 5'd1, 5'd2, 5'd3, 1, 0);
        step(1, T_J, 6'd0, 5'd0, 5'd0, 5'd0, 1, 0);
        check("stall_wreg", 32'(ex_wreg), 32'(12));
        check("stall_alu", 32'(ex_alu_ctrl), 32'(6'b100000));

        // Flush with HALT in ID
        step(1, T_HALT, 6'd0, 5'd0, 5'd0, 5'd0, 0, 1);
        check("flush_halt_pending", 32'(halt_pending), 32'(0));
        check("flush_valid", 32'(ex_valid), 32'(0));

        // XORI and illegal opcode
        step(1, T_XORI, 6'd0, 5'd2, 5'd20, 5'd1, 0, 0);
        check("xori_wreg", 32'(ex_wreg), 32'(20));
        check("xori_sext", 32'(ex_sign_ext), 32'(0));
        check("xori_alu", 32'(ex_alu_ctrl), 32'(6'b100110));
        step(1, T_BAD, 6'd0, 5'd2, 5'd3, 5'd1, 0, 0);
        check("illegal_pulse", 32'(illegal), 32'(1));
        check("illegal_bubble", 32'(ex_valid), 32'(0));
        step(0, T_R, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("illegal_clear", 32'(illegal), 32'(0));

        // Randomized traffic (no HALT)
        for (int i = 0; i < 400; i++) begin
            ro = rops[$urandom_range(rops.size() - 1)];
            step($urandom_range(99) < 85, ro, 6'($urandom), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom), $urandom_range(99) < 12,
                 $urandom_range(99) < 8);
        end

        // HALT drain with one external stall: halted after 5 cycles
        step(1, T_HALT, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("halt_accept", 32'(halt_pending), 32'(1));
        step(1, T_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0);
        step(1, T_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 1, 0);
        step(1, T_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0);
        step(1, T_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0);
        check("drain_not_yet", 32'(halted), 32'(0));
        step(1, T_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1);
        check("drain_halted", 32'(halted), 32'(1));
        step(1, T_LW, 6'd0, 5'd1, 5'd2, 5'd0, 0, 1);
        check("halted_sticky", 32'(halted), 32'(1));

        // Reset mid-drain
        do_reset();
        step(1, T_HALT, 6'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, T_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 0, 0);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ro = rops[$urandom_range(rops.size() - 1)];
            step($urandom_range(99) < 85, ro, 6'($urandom), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom), $urandom_range(99) < 12, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Registered, parametrised successor of the single-cycle instruction control decoder, sitting at the ID/EX boundary of the MIPS pipeline. Decodes `op`/`funct` of the instruction in ID into a control word and registers it for EX. Adds stall/flush handling, load-use hazard detection with bubble insertion, illegal-opcode flagging and a HALT drain sequencer that declares the core halted once the pipeline has emptied.

## Interface
Parameters:
- `ALUCTRL_W`, 6: width of `ex_alu_ctrl`; R-type `funct` is zero-extended or truncated to it.
- `MEMOP_W`, 3: width of `ex_mem_op` (one-hot byte/half/word).
- `DRAIN_CYCLES`, 4: cycles from HALT leaving ID until `halted`; range 1..15.
- `LOAD_USE_EN`, 1: 1 enables load-use detection; 0 ties `hazard_stall` to 0.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: ID holds a real instruction.
- `op` in 6: opcode.
- `funct` in 6: R-type function.
- `rs`, `rt`, `rd` in 5 each: register fields.
- `stall` in 1: external hold from later stages.
- `flush` in 1: branch/jump redirect; squash ID.
- `hazard_stall` out 1: combinational; hold PC and IF/ID.
- `ex_valid`, `ex_mem_to_reg`, `ex_mem_write`, `ex_mem_sign`, `ex_alu_src`, `ex_reg_write`, `ex_branch`, `ex_branch_eq`, `ex_jump`, `ex_sign_ext` out 1 each: registered control bits.
- `ex_alu_ctrl` out `ALUCTRL_W`; `ex_mem_op` out `MEMOP_W`; `ex_wreg` out 5: destination (rd for R-type, rt otherwise, 0 when no write).
- `illegal` out 1: registered one-cycle pulse for an undecodable valid opcode.
- `halt_pending` out 1, `halted` out 1: sticky.

## Operation
- Decode (combinational, the codebase's existing encodings): R-type 000000 → reg write, dst rd, ALU=funct. ADDI 001000 / ADDIU 010001 → ALU 100000, imm, sign-ext. ANDI 001100 / ORI 001101 / XORI 001110 → ALU 100100/100101/100110, imm, zero-ext, dst rt. SLTI 001010 / SLTIU 001011 → ALU 101010, sign-ext. BEQ 000100 / BNE 000101 → branch, `ex_branch_eq`=1/0, no write. J 000010 → jump. LB/LBU/LH/LHU/LW/LWU (100000/100100/100001/100101/100011/100111) → mem_to_reg, mem_op 001/010/100, mem_sign=1 for LB/LH/LW. SB/SH/SW (101000/101001/101011) → mem_write. HALT 111111 → halt request. Other → bubble + `illegal`.
- Bubble = all `ex_*` outputs 0.
- Load-use (valid_in, !halt_pending, `ex_valid & ex_mem_to_reg & ex_wreg!=0`): hit if `ex_wreg==rs` and op uses rs (all except J, HALT), or `ex_wreg==rt` and op uses rt (R-type, BEQ, BNE, stores). Hit → `hazard_stall`=1, bubble into EX.
- Register update priority: reset > `stall` (hold all) > `flush` (bubble, HALT in ID ignored) > `halt_pending` (bubble) > load-use (bubble) > decode.
- HALT accepted (valid, not flushed, not stalled, no hazard) → `halt_pending`=1, counter loads `DRAIN_CYCLES`, decrements each non-stalled cycle; at 0 `halted`=1. Both sticky until reset; flush does not clear them.

## Timing
- Reset: every output 0, counter 0.
- Decode latency 1 cycle: ID inputs at edge N appear on `ex_*` after edge N.
- `hazard_stall` same-cycle, exactly one cycle per load-use pair (next cycle EX holds bubble).
- `illegal` high exactly one cycle after the offending edge; suppressed under stall/flush.
- `halted` rises `DRAIN_CYCLES` non-stalled cycles after HALT is accepted.
- Reset mid-drain clears everything immediately.

## Structure
- Shared package `mips_pkg`: opcode localparams, ALU codes, mem-op encodings, control-word struct/field widths.
- Sub-module `control_decode`: pure combinational op/funct → control word + uses_rs/uses_rt/is_halt/is_illegal; this block adds registers, hazard and halt FSM (RUN → DRAIN → HALTED).

## Test plan
- Reset then ADDI op=001000 → next cycle `ex_alu_ctrl`=100000, `ex_alu_src`=1, `ex_sign_ext`=1, `ex_wreg`=rt.
- LW rt=5 then ADD rs=5 → `hazard_stall`=1 one cycle, EX bubble, ADD enters next cycle; same with rt=0 → no stall.
- `stall`=1 for 3 cycles with new IDs → `ex_*` unchanged; `flush` with HALT in ID → bubble, `halt_pending` stays 0.
- XORI → `ex_wreg`=rt, zero-ext; op=110011 valid → `illegal` one-cycle pulse, bubble.
- HALT, DRAIN_CYCLES=4, one external stall cycle during drain → `halted` after 5 cycles; `reset_n` low mid-drain → all outputs 0.
